// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the CPU data port and a wait-stated RAM plus LED, switch and counter peripherals.
// Optional sticky bus_err output is built when MIO_BUSERR_EN is defined.
module mio_bus_ctrl #(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              mio_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out
`ifdef MIO_BUSERR_EN
   ,
   output logic              bus_err
`endif
);

   // Handshake: cpu_req is held by the CPU until mio_ready, a one-cycle pulse
   // in RESP; cpu_req is not looked at outside IDLE, so no request is issued twice.
   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

   state_e              state_q;
   logic                ready_q;
   logic                ram_en_q;
   logic                ram_we_q;
   logic [RAM_AW-1:0]   ram_addr_q;
   logic [31:0]         ram_wdata_q;
   logic                acc_we_q;
   logic [3:0]          wcnt_q;
   logic [31:0]         rdata_q;
   logic [15:0]         led_q;
   logic [31:0]         cnt_q;
   logic [31:0]         cnt_d;

   logic [3:0]          region;
   logic                sel_ram;
   logic                sel_led;
   logic                sel_sw;
   logic                sel_cnt;
   logic                sel_unmapped;
   logic                accept;
   logic [31:0]         periph_rdata;
   logic                unused_addr;

   assign region       = cpu_addr[31:28];
   assign sel_ram      = ~cpu_addr[31];
   assign sel_led      = (region == 4'hE);
   assign sel_sw       = (region == 4'hF) && !cpu_addr[2];
   assign sel_cnt      = (region == 4'hF) &&  cpu_addr[2];
   assign sel_unmapped = !(sel_ram || sel_led || sel_sw || sel_cnt);
   assign accept       = (state_q == S_IDLE) && cpu_req;
   assign unused_addr  = ^cpu_addr;

   always_comb begin
      periph_rdata = 32'd0;
      if (sel_led) begin
         periph_rdata = {16'd0, led_q};
      end else if (sel_sw) begin
         periph_rdata = {16'd0, sw_in};
      end else if (sel_cnt) begin
         periph_rdata = cnt_q;
      end
   end

   // A counter write takes priority over that cycle's increment.
   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (accept && sel_cnt && cpu_we) begin
         cnt_d = cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'd0;
         acc_we_q    <= 1'b0;
         wcnt_q      <= 4'd0;
         rdata_q     <= 32'd0;
         led_q       <= 16'd0;
      end else begin
         ram_en_q <= 1'b0;
         ram_we_q <= 1'b0;
         ready_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_req) begin
                  if (sel_ram) begin
                     ram_en_q    <= 1'b1;
                     ram_we_q    <= cpu_we;
                     ram_addr_q  <= cpu_addr[RAM_AW+1:2];
                     ram_wdata_q <= cpu_wdata;
                     acc_we_q    <= cpu_we;
                     wcnt_q      <= WAIT_INIT;
                     state_q     <= S_WAIT;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= S_RESP;
                     if (cpu_we) begin
                        if (sel_led) begin
                           led_q <= cpu_wdata[15:0];
                        end
                     end else begin
                        rdata_q <= periph_rdata;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (wcnt_q == 4'd0) begin
                  if (!acc_we_q) begin
                     rdata_q <= ram_rdata;
                  end
                  ready_q <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MIO_BUSERR_EN
   logic err_q;

   // Sticky until reset; the offending access itself still completes normally.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept && (sel_unmapped || (sel_sw && cpu_we))) begin
         err_q <= 1'b1;
      end
   end

   assign bus_err = err_q;
`endif

   assign cpu_rdata = rdata_q;
   assign mio_ready = ready_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign led_out   = led_q;

endmodule
